// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the Mem-stage data memory sequencer.
// Holds the loadCtrl/saveCtrl codes, the sequencer state encoding, and the
// per-size alignment checks used in IDLE.
package dm_ctrl_pkg;

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LW  = 3'd5;

  localparam logic [2:0] ST_SB  = 3'd1;
  localparam logic [2:0] ST_SH  = 3'd2;
  localparam logic [2:0] ST_SW  = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unknown codes fall into the word case, so they need a word-aligned address.
  function automatic logic ld_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl)
      LD_LB, LD_LBU: ld_misaligned = 1'b0;
      LD_LH, LD_LHU: ld_misaligned = off[0];
      default:       ld_misaligned = |off;
    endcase
  endfunction

  function automatic logic st_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl)
      ST_SB:   st_misaligned = 1'b0;
      ST_SH:   st_misaligned = off[0];
      default: st_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load data extension: selects a byte or half from a memory word and sign-
// or zero-extends it. Purely combinational.
// Ports: i_word (memory word), i_off (byte offset), i_loadCtrl (load code) -> o_data.
module dm_load_ext
  import dm_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_loadCtrl,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    case (i_loadCtrl)
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {24'd0, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_data = {16'd0, w_half};
      LD_LW:   o_data = i_word;
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Mem-stage data memory sequencer: issues one memory access per request,
// waits LATENCY cycles for load data, extends it, and stalls the pipeline.
// Ports: pipeline request (ifLoad/ifSave/ctrl/addr/wData), pipeline response
// (stall/done/rData/addrErr), word-organised memory (memEn/We/Addr/Be/Wdata/Rdata).
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ifLoad,
  input  logic        i_ifSave,
  input  logic [2:0]  i_loadCtrl,
  input  logic [2:0]  i_saveCtrl,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wData,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rData,
  output logic        o_addrErr,
  output logic        o_memEn,
  output logic        o_memWe,
  output logic [31:0] o_memAddr,
  output logic [3:0]  o_memBe,
  output logic [31:0] o_memWdata,
  input  logic [31:0] i_memRdata
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_ld_ctrl;
  logic [1:0]       r_off;
  logic             r_is_load;
  logic [31:0]      r_data;

  logic        w_req;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_idle;
  logic        w_issue;
  logic [3:0]  w_be;
  logic [31:0] w_wdat;
  logic [31:0] w_ext;

  // A request with both flags set is a load; the store flag is ignored.
  assign w_req      = i_ifLoad | i_ifSave;
  assign w_is_store = i_ifSave & ~i_ifLoad;
  assign w_misalign = i_ifLoad ? ld_misaligned(i_loadCtrl, i_addr[1:0])
                               : (i_ifSave & st_misaligned(i_saveCtrl, i_addr[1:0]));
  assign w_idle     = (r_state == IDLE);

  // Everything combinational is gated by reset so outputs read 0 while it is held.
  assign w_issue   = ~i_reset & w_idle & w_req & ~w_misalign;
  assign o_addrErr = ~i_reset & w_idle & w_misalign;
  assign o_stall   = ~i_reset & w_req & ~o_addrErr & (r_state != RESP);
  assign o_done    = ~i_reset & (r_state == RESP);

  assign o_memEn    = w_issue;
  assign o_memWe    = w_issue & w_is_store;
  assign o_memAddr  = w_issue ? {i_addr[31:2], 2'b00} : 32'd0;
  assign o_memBe    = w_be;
  assign o_memWdata = w_wdat;

  always_comb begin
    w_be   = 4'b0000;
    w_wdat = 32'd0;
    if (w_issue) begin
      if (w_is_store) begin
        case (i_saveCtrl)
          ST_SB: begin
            w_be   = 4'b0001 << i_addr[1:0];
            w_wdat = {4{i_wData[7:0]}};
          end
          ST_SH: begin
            w_be   = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdat = {2{i_wData[15:0]}};
          end
          ST_SW: begin
            w_be   = 4'b1111;
            w_wdat = i_wData;
          end
          default: begin
            w_be   = 4'b1111;
            w_wdat = i_wData;
          end
        endcase
      end else begin
        w_be = 4'b1111;
      end
    end
  end

  // Extension works off latched controls so RESP ignores the next instruction.
  dm_load_ext u_load_ext (
    .i_word     (r_data),
    .i_off      (r_off),
    .i_loadCtrl (r_ld_ctrl),
    .o_data     (w_ext)
  );

  assign o_rData = (o_done & r_is_load) ? w_ext : 32'd0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ld_ctrl <= 3'd0;
      r_off     <= 2'd0;
      r_is_load <= 1'b0;
      r_data    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_ld_ctrl <= i_loadCtrl;
            r_off     <= i_addr[1:0];
            r_is_load <= i_ifLoad;
            if (i_ifLoad) begin
              r_cnt   <= CNT_W'(LATENCY - 1);
              r_state <= BUSY;
            end else begin
              // Stores are posted: no read data to wait for.
              r_state <= RESP;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_data  <= i_memRdata;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Multi-cycle sequencer for the data memory behind the Mem pipeline stage.
- Takes the Mem-stage load/store request (loadCtrl/saveCtrl codes, ALU address, forwarded store data).
- Drives a word-organised memory with fixed read latency and generates byte enables and store-data lanes.
- Extends load data, detects misaligned accesses, and stalls the pipeline until the access completes.

Parameters:
- LATENCY, 2, memory read latency in cycles from issue to valid memRdata; legal range 1..7.
- CNT_W, 3, width of the latency counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ifLoad  in  1  Mem-stage instruction is a load
- ifSave  in  1  Mem-stage instruction is a store
- loadCtrl  in  3  1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw
- saveCtrl  in  3  1 sb, 2 sh, 3 sw
- addr  in  32  byte address (ALU result)
- wData  in  32  store data, already forwarded
- stall  out  1  freeze PC/IF/ID/EX/Mem pipeline registers
- done  out  1  access complete this cycle
- rData  out  32  extended load result, valid while done=1 for loads
- addrErr  out  1  misaligned access detected
- memEn  out  1  memory access strobe, one cycle per access
- memWe  out  1  write strobe, qualified by memEn
- memAddr  out  32  word address: {addr[31:2],2'b00}
- memBe  out  4  byte enables, little-endian
- memWdata  out  32  lane-aligned store data
- memRdata  in  32  memory read word, valid LATENCY cycles after issue

Behaviour:
- Reset: asynchronous; FSM goes to IDLE, counter cleared, latched controls cleared. All outputs are 0 during reset and in IDLE with no request.
- Request: req = ifLoad | ifSave. If both are set, the access is treated as a load and memWe stays 0.
- Alignment check (combinational, IDLE only):
  - lh/lhu/sh misaligned when addr[0]=1.
  - lw/sw misaligned when addr[1:0]≠0.
  - Byte accesses are never misaligned.
  - On misalignment: addrErr=1, memEn=0, stall=0, done=0, FSM stays in IDLE.
- States: IDLE, BUSY, RESP.
- IDLE with an aligned request:
  - memEn=1 this cycle.
  - Latch loadCtrl and addr[1:0].
  - Load: memWe=0, counter←LATENCY-1, next state BUSY.
  - Store: memWe=1, next state RESP. Stores are posted.
- BUSY: counter decrements each cycle. When counter=0, capture memRdata into the data register and go to RESP.
- RESP: done=1 and rData is driven from the captured word. Unconditionally return to IDLE.
- stall = req & ~addrErr & (state≠RESP). The pipeline therefore advances on the edge that leaves RESP.
- Latency in Mem stage:
  - Load: LATENCY+2 cycles. With LATENCY=2: issue, BUSY×2, RESP = 4 cycles.
  - Store: 2 cycles.
- Byte enables and store data:
  - sb: memBe = 1<<addr[1:0]; memWdata = {4{wData[7:0]}}.
  - sh: memBe = addr[1] ? 1100 : 0011; memWdata = {2{wData[15:0]}}.
  - sw: memBe = 1111; memWdata = wData.
  - For loads, memBe = 1111.
  - All of memAddr, memBe and memWdata are 0 whenever memEn=0.
- Load extension, using the latched addr[1:0]:
  - lb/lbu select byte addr[1:0] and sign- or zero-extend.
  - lh/lhu select the half addr[1] and sign- or zero-extend.
  - lw passes the word through.
- Inputs may change only after done. Latched controls make RESP independent of the next instruction already present at the inputs.
- Invalid ctrl code (0, 6, 7) with a request: treated as a word access, no special handling.
- Reset asserted in BUSY or RESP: abort immediately to IDLE, stall=0, done never pulses. A store already issued is not undone.

Decomposition:
- Shared package dm_ctrl_pkg holds:
  - localparams for the loadCtrl codes (LD_LB..LD_LW) and saveCtrl codes (ST_SB..ST_SW);
  - the state encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
- One sub-module, dm_load_ext: purely combinational byte/half select and extension, with inputs word, off[1:0] and loadCtrl. It is reused by any future cache path.

Test Plan:
- Reset, then sw addr=0x10, wData=0xDEADBEEF → one cycle memEn=1, memWe=1, memBe=1111, memAddr=0x10; stall=1 for 1 cycle; done=1 in the next cycle.
- LATENCY=2, lb addr=0x13, memRdata=0x80112233 → stall high 3 cycles, memEn pulses once; RESP rData=0xFFFFFF80. Repeat with lbu → rData=0x00000080.
- sh addr=0x22, wData=0x0000ABCD → memBe=1100, memWdata=0xABCDABCD, memAddr=0x20. Then lh addr=0x22, memRdata=0x8001ABCD → rData=0xFFFF8001.
- lw addr=0x06 → addrErr=1, memEn=0, stall=0, FSM stays IDLE. Also sh addr=0x03 → addrErr=1.
- Back-to-back lw 0x00 then lw 0x04 (inputs change on the edge leaving RESP) → exactly two memEn pulses, second issue in the cycle after RESP; each rData matches its own memRdata.
- Assert reset in the second BUSY cycle → stall and all outputs 0 immediately; a subsequent lw issues normally with full latency.
